// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Function : Program loader for the CPU instruction memory. Receives a framed
//            byte stream (SYNC, ADDR, LEN, data bytes) over valid/ready and
//            issues one single-cycle instruction write per data byte, holding
//            the CPU while a frame is in progress.
// Options  : PROG_LOADER_CKSUM_EN - when defined, each frame carries a
//            trailing checksum byte (ADDR + LEN + data, mod 256).
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE   = 'hA5,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              inst_we,
    output logic [ADDR_W-1:0] inst_address,
    output logic [DATA_W-1:0] inst_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Remaining-count width must hold both any LEN byte and 2^ADDR_W (LEN=0).
    localparam int c_CNT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_LEN = c_CNT_W'(1) << ADDR_W;
    localparam logic [7:0]         c_TIMEOUT  = 8'(TIMEOUT_CYC);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef PROG_LOADER_CKSUM_EN
    localparam logic [2:0] S_CKSUM = 3'd5;
`endif

    logic [2:0]         r_state;
    logic               r_ready;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_hold;
    logic               r_done;
    logic               r_err;
    logic [ADDR_W-1:0]  r_ptr;
    logic [c_CNT_W-1:0] r_remain;
    logic [7:0]         r_idle;
`ifdef PROG_LOADER_CKSUM_EN
    logic [DATA_W-1:0]  r_sum;
`endif

    logic               w_accept;
    logic               w_in_frame;
    logic [7:0]         w_idle_inc;
    logic [c_CNT_W-1:0] w_len_load;

    assign w_accept   = in_valid & r_ready;
    assign w_in_frame = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_idle_inc = r_idle + 8'd1;
    assign w_len_load = (in_data == '0) ? c_FULL_LEN : c_CNT_W'(in_data);

    assign in_ready     = r_ready;
    assign inst_we      = r_we;
    assign inst_address = r_addr;
    assign inst_data    = r_data;
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign err          = r_err;

    // Frame-parsing FSM with registered outputs; idle timeout aborts an open frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_hold   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ptr    <= '0;
            r_remain <= '0;
            r_idle   <= '0;
`ifdef PROG_LOADER_CKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_idle  <= '0;
                    if (w_accept && (in_data == SYNC_BYTE)) begin
                        r_state <= S_ADDR;
                        r_hold  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (w_accept) begin
                        r_ptr   <= in_data[ADDR_W-1:0];
                        r_state <= S_LEN;
`ifdef PROG_LOADER_CKSUM_EN
                        r_sum   <= in_data;
`endif
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_remain <= w_len_load;
                        r_state  <= S_DATA;
`ifdef PROG_LOADER_CKSUM_EN
                        r_sum    <= r_sum + in_data;
`endif
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_we     <= 1'b1;
                        r_addr   <= r_ptr;
                        r_data   <= in_data;
                        r_ptr    <= r_ptr + 1'b1;
                        r_remain <= r_remain - 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
                        r_sum    <= r_sum + in_data;
                        if (r_remain == c_CNT_W'(1)) begin
                            r_state <= S_CKSUM;
                        end
`else
                        if (r_remain == c_CNT_W'(1)) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                        end
`endif
                    end
                end
`ifdef PROG_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (w_accept) begin
                        if (in_data == r_sum) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_hold  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_hold  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase

            // Idle watchdog: overrides the case above only on cycles without an accept.
            if (w_in_frame) begin
                if (w_accept) begin
                    r_idle <= '0;
                end else if (w_idle_inc == c_TIMEOUT) begin
                    r_idle  <= '0;
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                    r_err   <= 1'b1;
                end else begin
                    r_idle <= w_idle_inc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Function : Self-checking bench for prog_loader. A cycle-by-cycle vector
//            table covers basic load, stalls, DONE backpressure and resync;
//            directed sequences cover wrap, LEN=0, timeout, checksum
//            (PROG_LOADER_CKSUM_EN) and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

`ifdef PROG_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic       inst_we;
    logic [6:0] inst_address;
    logic [7:0] inst_data;
    logic       cpu_hold;
    logic       done;
    logic       err;

    prog_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .inst_we      (inst_we),
        .inst_address (inst_address),
        .inst_data    (inst_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       we;
        logic [6:0] a;
        logic [7:0] wd;
        logic       hold;
        logic       dn;
        logic       er;
        logic       rdy;
    } vec_t;

    vec_t        vt[$];
    logic [14:0] wq[$];
    logic [7:0]  fb[$];
    int          done_cnt = 0;
    int          n_cmp    = 0;
    int          n_bad    = 0;

    // Record every write strobe and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_we) wq.push_back({inst_address, inst_data});
            if (done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic v, input logic [7:0] d, input logic we,
                                 input logic [6:0] a, input logic [7:0] wd, input logic hold,
                                 input logic dn, input logic er, input logic rdy);
        vec_t t;
        t.v = v; t.d = d; t.we = we; t.a = a; t.wd = wd;
        t.hold = hold; t.dn = dn; t.er = er; t.rdy = rdy;
        vt.push_back(t);
    endfunction

    function automatic logic [7:0] frame_sum();
        logic [7:0] s = 8'h00;
        for (int i = 1; i < fb.size(); i++) s = s + fb[i];
        return s;
    endfunction

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] d);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_stream(input bit add_ck);
        logic [7:0] s;
        s = frame_sum();
        for (int i = 0; i < fb.size(); i++) send_byte(fb[i]);
        if (add_ck) send_byte(s);
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int bad;
        vec_t t;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {25'd0, in_ready, inst_we, cpu_hold, done, err, |inst_address, |inst_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // ---------------- vector table ----------------
        push(1, 8'hA5, 0, 7'h00, 8'h00, 1, 0, 0, 1);
        push(1, 8'h10, 0, 7'h00, 8'h00, 1, 0, 0, 1);
        push(0, 8'h55, 0, 7'h00, 8'h00, 1, 0, 0, 1);
        push(1, 8'h03, 0, 7'h00, 8'h00, 1, 0, 0, 1);
        push(1, 8'h11, 1, 7'h10, 8'h11, 1, 0, 0, 1);
        push(0, 8'h77, 0, 7'h10, 8'h11, 1, 0, 0, 1);
        push(1, 8'h22, 1, 7'h11, 8'h22, 1, 0, 0, 1);
        push(1, 8'h33, 1, 7'h12, 8'h33, 1, 0, 0, CK);
        if (CK) push(1, 8'h79, 0, 7'h12, 8'h33, 1, 0, 0, 0);
        push(1, 8'hA5, 0, 7'h12, 8'h33, 0, 1, 0, 1);
        push(1, 8'h00, 0, 7'h12, 8'h33, 0, 0, 0, 1);
        push(1, 8'hFF, 0, 7'h12, 8'h33, 0, 0, 0, 1);
        push(1, 8'hA5, 0, 7'h12, 8'h33, 1, 0, 0, 1);
        push(1, 8'h05, 0, 7'h12, 8'h33, 1, 0, 0, 1);
        push(1, 8'h01, 0, 7'h12, 8'h33, 1, 0, 0, 1);
        push(1, 8'hA5, 1, 7'h05, 8'hA5, 1, 0, 0, CK);
        if (CK) push(1, 8'hAB, 0, 7'h05, 8'hA5, 1, 0, 0, 0);
        push(0, 8'h00, 0, 7'h05, 8'hA5, 0, 1, 0, 1);
        push(0, 8'h00, 0, 7'h05, 8'hA5, 0, 0, 0, 1);

        for (int i = 0; i < vt.size(); i++) begin
            t = vt[i];
            in_valid = t.v;
            in_data  = t.d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d{we,addr,data,hold,done,err,ready}", i),
                  {12'd0, inst_we, inst_address, inst_data, cpu_hold, done, err, in_ready},
                  {12'd0, t.we, t.a, t.wd, t.hold, t.dn, t.er, t.rdy});
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // ---------------- address wrap ----------------
        wq.delete(); d0 = done_cnt;
        fb = '{8'hA5, 8'h7E, 8'h02, 8'hAA, 8'hBB};
        send_stream(CK);
        repeat (3) @(negedge clk);
        check("wrap_count", wq.size(), 2);
        check("wrap_w0", {17'd0, wq[0]}, {17'd0, 7'h7E, 8'hAA});
        check("wrap_w1", {17'd0, wq[1]}, {17'd0, 7'h7F, 8'hBB});
        check("wrap_done", done_cnt - d0, 1);

        // ---------------- LEN = 0 means 128 bytes ----------------
        wq.delete(); d0 = done_cnt;
        fb = '{8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 128; i++) fb.push_back(8'(i * 3 + 1));
        send_stream(CK);
        repeat (3) @(negedge clk);
        check("len0_count", wq.size(), 128);
        bad = 0;
        for (int i = 0; i < 128 && i < wq.size(); i++)
            if (wq[i] !== {7'(i), 8'(i * 3 + 1)}) bad++;
        check("len0_bad_writes", bad, 0);
        check("len0_done", done_cnt - d0, 1);

        // ---------------- idle timeout ----------------
        wq.delete(); d0 = done_cnt;
        fb = '{8'hA5, 8'h20, 8'h04, 8'h01};
        send_stream(1'b0);
        repeat (254) @(negedge clk);
        check("timeout_not_yet_err", {31'd0, err}, 32'd0);
        check("timeout_not_yet_hold", {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        check("timeout_err", {31'd0, err}, 32'd1);
        check("timeout_hold", {31'd0, cpu_hold}, 32'd0);
        check("timeout_no_done", done_cnt - d0, 0);
        check("timeout_writes", wq.size(), 1);
        check("timeout_w0", {17'd0, wq[0]}, {17'd0, 7'h20, 8'h01});
        send_byte(8'hA5);
        in_valid = 1'b0;
        check("sync_clears_err", {31'd0, err}, 32'd0);
        check("sync_sets_hold", {31'd0, cpu_hold}, 32'd1);

        // ---------------- async reset mid-DATA ----------------
        send_byte(8'h30);
        send_byte(8'h14);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'h40 + 8'(k);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {25'd0, in_ready, inst_we, cpu_hold, done, err, |inst_address, |inst_data}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        wq.delete(); d0 = done_cnt;
        fb = '{8'hA5, 8'h40, 8'h02, 8'hC3, 8'h3C};
        send_stream(CK);
        repeat (3) @(negedge clk);
        check("post_reset_count", wq.size(), 2);
        check("post_reset_w0", {17'd0, wq[0]}, {17'd0, 7'h40, 8'hC3});
        check("post_reset_w1", {17'd0, wq[1]}, {17'd0, 7'h41, 8'h3C});
        check("post_reset_done", done_cnt - d0, 1);

`ifdef PROG_LOADER_CKSUM_EN
        // ---------------- checksum match / mismatch ----------------
        wq.delete(); d0 = done_cnt;
        fb = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h15};
        send_stream(1'b0);
        repeat (3) @(negedge clk);
        check("ck_good_done", done_cnt - d0, 1);
        check("ck_good_err", {31'd0, err}, 32'd0);
        wq.delete(); d0 = done_cnt;
        fb = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h16};
        send_stream(1'b0);
        repeat (3) @(negedge clk);
        check("ck_bad_no_done", done_cnt - d0, 0);
        check("ck_bad_err", {31'd0, err}, 32'd1);
        check("ck_bad_hold", {31'd0, cpu_hold}, 32'd0);
        check("ck_bad_writes", wq.size(), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
